// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into K x K convolution
// windows (valid positions only, stride 1) for the integer convolution PE.
// K-1 line memories feed a K x K shift window. Each complete window is
// captured into a registered output array and flagged by a one-cycle strobe.
module conv_window_gen #(
  parameter int pic_bits    = 2,
  parameter int kernel_size = 5,
  parameter int img_width   = 28,
  parameter int img_height  = 28
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic [pic_bits-1:0]           pix_in,
  output logic [pic_bits-1:0]           pic [kernel_size*kernel_size],
  output logic                          win_valid,
  output logic [$clog2(img_height)-1:0] win_row,
  output logic [$clog2(img_width)-1:0]  win_col,
  output logic                          frame_done
);

  localparam int K  = kernel_size;
  localparam int CW = $clog2(img_width);
  localparam int RW = $clog2(img_height);

  localparam logic [CW-1:0] COL_LAST      = CW'(img_width - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(img_height - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);

  // Raster position of the next pixel to be accepted.
  logic [CW-1:0] col_cnt_r;
  logic [RW-1:0] row_cnt_r;

  // line_r[0] holds the previous row and line_r[K-2] holds the oldest buffered row.
  logic [pic_bits-1:0] line_r [K-1][img_width];

  // Shift window. win_r[r][c] uses r=0 for the top row and c=0 for the leftmost column.
  logic [pic_bits-1:0] win_r     [K][K];
  logic [pic_bits-1:0] win_nxt_s [K][K];
  logic [pic_bits-1:0] col_vec_s [K];

  logic emit_s;
  logic frame_end_s;

  // Raster counters. The column wraps first, then the row wraps at end of frame.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col_cnt_r <= '0;
      row_cnt_r <= '0;
    end else if (pix_valid) begin
      if (col_cnt_r == COL_LAST) begin
        col_cnt_r <= '0;
        if (row_cnt_r == ROW_LAST) begin
          row_cnt_r <= '0;
        end else begin
          row_cnt_r <= row_cnt_r + RW'(1);
        end
      end else begin
        col_cnt_r <= col_cnt_r + CW'(1);
      end
    end
  end

  // Line memories cascade one row older at the current column. They are not reset
  // because window gating depends only on the counters.
  always_ff @(posedge clk) begin
    if (!rst_n && pix_valid) begin
      line_r[0][col_cnt_r] <= pix_in;
      for (int i = 1; i < K - 1; i++) begin
        line_r[i][col_cnt_r] <= line_r[i-1][col_cnt_r];
      end
    end
  end

  // Incoming column, oldest row first, and the window after shifting it in.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_vec_s[r] = line_r[K-2-r][col_cnt_r];
    end
    col_vec_s[K-1] = pix_in;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt_s[r][c] = win_r[r][c+1];
      end
      win_nxt_s[r][K-1] = col_vec_s[r];
    end
  end

  // Window emission and end-of-frame detection for the current beat.
  always_comb begin
    emit_s      = 1'b0;
    frame_end_s = 1'b0;
    if (pix_valid && (row_cnt_r >= ROW_FIRST_WIN) && (col_cnt_r >= COL_FIRST_WIN)) begin
      emit_s = 1'b1;
    end else begin
      emit_s = 1'b0;
    end
    if (pix_valid && (row_cnt_r == ROW_LAST) && (col_cnt_r == COL_LAST)) begin
      frame_end_s = 1'b1;
    end else begin
      frame_end_s = 1'b0;
    end
  end

  // Shift window advances on every accepted beat, including beats across row wraps.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_r[r][c] <= '0;
        end
      end
    end else if (pix_valid) begin
      win_r <= win_nxt_s;
    end
  end

  // Registered outputs. pic and the indices load only when a window is emitted and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      for (int i = 0; i < K * K; i++) begin
        pic[i] <= '0;
      end
    end else begin
      win_valid  <= emit_s;
      frame_done <= frame_end_s;
      if (emit_s) begin
        win_row <= row_cnt_r - ROW_FIRST_WIN;
        win_col <= col_cnt_r - COL_FIRST_WIN;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            pic[r*K+c] <= win_nxt_s[r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen. A small instance (K=3, 4x4) covers
// the streaming, gap, reset and back-to-back scenarios. A default-parameter
// instance is checked window by window against a closed-form golden model.
module tb_conv_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: K=3, W=H=4, 8-bit pixels
  logic       s_rst;
  logic       s_valid;
  logic [7:0] s_pix;
  logic [7:0] s_pic [9];
  logic       s_wv;
  logic [1:0] s_row;
  logic [1:0] s_col;
  logic       s_fd;

  // Default instance: K=5, 28x28, 2-bit pixels
  logic       d_rst;
  logic       d_valid;
  logic [1:0] d_pix;
  logic [1:0] d_pic [25];
  logic       d_wv;
  logic [4:0] d_row;
  logic [4:0] d_col;
  logic       d_fd;

  int checks = 0;
  int errors = 0;

  conv_window_gen #(.pic_bits(8), .kernel_size(3), .img_width(4), .img_height(4)) dut_s (
    .clk(clk), .rst_n(s_rst), .pix_valid(s_valid), .pix_in(s_pix),
    .pic(s_pic), .win_valid(s_wv), .win_row(s_row), .win_col(s_col), .frame_done(s_fd)
  );

  conv_window_gen #(.pic_bits(2), .kernel_size(5), .img_width(28), .img_height(28)) dut_d (
    .clk(clk), .rst_n(d_rst), .pix_valid(d_valid), .pix_in(d_pix),
    .pic(d_pic), .win_valid(d_wv), .win_row(d_row), .win_col(d_col), .frame_done(d_fd)
  );

  task automatic drive_s(input logic rst, input logic vld, input logic [7:0] v);
    @(negedge clk);
    s_rst = rst; s_valid = vld; s_pix = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic rst, input logic vld, input logic [1:0] v);
    @(negedge clk);
    d_rst = rst; d_valid = vld; d_pix = v;
    @(posedge clk);
    #1;
  endtask

  // One 4x4 frame of values base..base+15, with up to max_idle idle cycles after each beat.
  task automatic test_frame_small(input int base, input int max_idle, output int strobes, output int dones);
    logic       have_win;
    logic [7:0] last_br;
    strobes  = 0;
    dones    = 0;
    have_win = 1'b0;
    last_br  = 8'd0;
    for (int k = 0; k < 16; k++) begin
      int r, c, n;
      logic exp_wv;
      logic [7:0] exp_v;
      r = k / 4; c = k % 4;
      exp_wv = (r >= 2 && c >= 2);
      drive_s(1'b0, 1'b1, 8'(base + k));
      checks++;
      if (s_wv !== exp_wv) begin
        errors++; $display("FAIL small_win_valid base %0d beat %0d: got %b expected %b", base, k, s_wv, exp_wv);
      end
      checks++;
      if (s_fd !== (k == 15)) begin
        errors++; $display("FAIL small_frame_done base %0d beat %0d: got %b expected %b", base, k, s_fd, (k == 15));
      end
      if (s_wv) strobes++;
      if (s_fd) dones++;
      if (exp_wv) begin
        checks++;
        if (s_row !== 2'(r - 2)) begin
          errors++; $display("FAIL small_win_row beat %0d: got %0d expected %0d", k, s_row, r - 2);
        end
        checks++;
        if (s_col !== 2'(c - 2)) begin
          errors++; $display("FAIL small_win_col beat %0d: got %0d expected %0d", k, s_col, c - 2);
        end
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            exp_v = 8'(base + (r - 2 + i) * 4 + (c - 2 + j));
            checks++;
            if (s_pic[i*3+j] !== exp_v) begin
              errors++; $display("FAIL small_pic[%0d] beat %0d: got %0d expected %0d", i*3+j, k, s_pic[i*3+j], exp_v);
            end
          end
        end
        have_win = 1'b1;
        last_br  = 8'(base + k);
      end
      n = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
      for (int g = 0; g < n; g++) begin
        drive_s(1'b0, 1'b0, 8'hEE);
        checks++;
        if (s_wv !== 1'b0 || s_fd !== 1'b0) begin
          errors++; $display("FAIL idle_strobe beat %0d: got wv=%b fd=%b expected 0 0", k, s_wv, s_fd);
        end
        if (have_win) begin
          checks++;
          if (s_pic[8] !== last_br) begin
            errors++; $display("FAIL idle_pic_hold beat %0d: got %0d expected %0d", k, s_pic[8], last_br);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic bad;
    drive_s(1'b1, 1'b0, 8'd0);
    drive_d(1'b1, 1'b0, 2'd0);
    drive_s(1'b0, 1'b0, 8'd0);
    d_rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 9; i++) if (s_pic[i] !== 8'd0) bad = 1'b1;
    for (int i = 0; i < 25; i++) if (d_pic[i] !== 2'd0) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL reset_pic: got nonzero entry expected all 0"); end
    checks++;
    if ({s_wv, s_fd, s_row, s_col} !== 6'd0) begin
      errors++; $display("FAIL reset_small_outs: got %b expected 000000", {s_wv, s_fd, s_row, s_col});
    end
    checks++;
    if ({d_wv, d_fd, d_row, d_col} !== 12'd0) begin
      errors++; $display("FAIL reset_default_outs: got %b expected 0", {d_wv, d_fd, d_row, d_col});
    end
  endtask

  task automatic test_basic_stream();
    int st, dn;
    test_frame_small(0, 0, st, dn);
    checks++;
    if (st != 4 || dn != 1) begin
      errors++; $display("FAIL basic_counts: got %0d strobes %0d dones expected 4 1", st, dn);
    end
  endtask

  task automatic test_idle_gaps();
    int st, dn;
    test_frame_small(0, 3, st, dn);
    checks++;
    if (st != 4 || dn != 1) begin
      errors++; $display("FAIL gaps_counts: got %0d strobes %0d dones expected 4 1", st, dn);
    end
  endtask

  task automatic test_mid_frame_reset();
    int st, dn;
    logic bad;
    for (int k = 0; k <= 6; k++) begin
      drive_s(1'b0, 1'b1, 8'(k));
      checks++;
      if (s_wv !== 1'b0) begin errors++; $display("FAIL prereset_strobe beat %0d: got %b expected 0", k, s_wv); end
    end
    drive_s(1'b1, 1'b0, 8'd0);
    bad = 1'b0;
    for (int i = 0; i < 9; i++) if (s_pic[i] !== 8'd0) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL midreset_pic: got nonzero entry expected all 0"); end
    checks++;
    if ({s_wv, s_fd, s_row, s_col} !== 6'd0) begin
      errors++; $display("FAIL midreset_outs: got %b expected 000000", {s_wv, s_fd, s_row, s_col});
    end
    test_frame_small(0, 0, st, dn);
    checks++;
    if (st != 4 || dn != 1) begin
      errors++; $display("FAIL midreset_counts: got %0d strobes %0d dones expected 4 1", st, dn);
    end
  endtask

  task automatic test_back_to_back();
    int st1, dn1, st2, dn2;
    test_frame_small(0, 0, st1, dn1);
    test_frame_small(16, 0, st2, dn2);
    checks++;
    if (st1 + st2 != 8 || dn1 + dn2 != 2) begin
      errors++; $display("FAIL b2b_counts: got %0d strobes %0d dones expected 8 2", st1 + st2, dn1 + dn2);
    end
  endtask

  task automatic test_reset_with_pixel();
    int st, dn;
    drive_s(1'b1, 1'b1, 8'd99);
    checks++;
    if (s_wv !== 1'b0) begin errors++; $display("FAIL rstpix_strobe: got %b expected 0", s_wv); end
    test_frame_small(0, 0, st, dn);
    checks++;
    if (st != 4 || dn != 1) begin
      errors++; $display("FAIL rstpix_counts: got %0d strobes %0d dones expected 4 1", st, dn);
    end
  endtask

  task automatic test_default_frame();
    int strobes, dones;
    int rmin, rmax, cmin, cmax;
    strobes = 0; dones = 0;
    rmin = 99; rmax = -1; cmin = 99; cmax = -1;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        logic exp_wv;
        logic ok;
        int bad_i;
        drive_d(1'b0, 1'b1, 2'((r + c) % 4));
        exp_wv = (r >= 4 && c >= 4);
        checks++;
        if (d_wv !== exp_wv) begin
          errors++; $display("FAIL dflt_win_valid (%0d,%0d): got %b expected %b", r, c, d_wv, exp_wv);
        end
        checks++;
        if (d_fd !== (r == 27 && c == 27)) begin
          errors++; $display("FAIL dflt_frame_done (%0d,%0d): got %b", r, c, d_fd);
        end
        if (d_fd) dones++;
        if (d_wv) begin
          strobes++;
          if (int'(d_row) < rmin) rmin = int'(d_row);
          if (int'(d_row) > rmax) rmax = int'(d_row);
          if (int'(d_col) < cmin) cmin = int'(d_col);
          if (int'(d_col) > cmax) cmax = int'(d_col);
        end
        if (exp_wv) begin
          checks++;
          if (d_row !== 5'(r - 4) || d_col !== 5'(c - 4)) begin
            errors++; $display("FAIL dflt_index (%0d,%0d): got (%0d,%0d) expected (%0d,%0d)", r, c, d_row, d_col, r - 4, c - 4);
          end
          ok = 1'b1; bad_i = -1;
          for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
              if (ok && d_pic[i*5+j] !== 2'((r - 4 + i + c - 4 + j) % 4)) begin
                ok = 1'b0; bad_i = i * 5 + j;
              end
            end
          end
          checks++;
          if (!ok) begin
            errors++; $display("FAIL dflt_window (%0d,%0d): entry %0d got %0d", r, c, bad_i, d_pic[bad_i]);
          end
        end
      end
    end
    d_valid = 1'b0;
    checks++;
    if (strobes != 576 || dones != 1) begin
      errors++; $display("FAIL dflt_counts: got %0d strobes %0d dones expected 576 1", strobes, dones);
    end
    checks++;
    if (rmin != 0 || rmax != 23 || cmin != 0 || cmax != 23) begin
      errors++; $display("FAIL dflt_span: got row %0d..%0d col %0d..%0d expected 0..23", rmin, rmax, cmin, cmax);
    end
  endtask

  initial begin
    s_rst = 1'b1; s_valid = 1'b0; s_pix = 8'd0;
    d_rst = 1'b1; d_valid = 1'b0; d_pix = 2'd0;
    test_reset();
    test_basic_stream();
    test_idle_gaps();
    test_mid_frame_reset();
    test_back_to_back();
    test_reset_with_pixel();
    test_default_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
